wb_arbiter: RTL and testbench

- Writeback-side producer for the multi-port register file.
- Collects results from N functional units over valid/ready handshakes and buffers them in small per-source FIFOs.
- Each cycle, grants up to num_write_ports results round-robin and drives registered ld/dest/in port arrays straight into the register file's write ports.
- Sits between the execute units and the rrd-stage register file.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_fifo.sv | 49 ++++
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter: the buffered result entry
// and the architectural zero register that is never written.
package wb_pkg;
    localparam int WB_NUM_SOURCES     = 4;
    localparam int WB_NUM_WRITE_PORTS = 3;
    localparam int WB_S_INDEX         = 5;
    localparam int WB_S_WIDTH         = 32;
    localparam int WB_FIFO_DEPTH      = 2;

    typedef struct packed {
        logic [WB_S_INDEX-1:0] dest;
        logic [WB_S_WIDTH-1:0] data;
    } wb_entry_t;

    localparam logic [WB_S_INDEX-1:0] WB_ZERO_REG = '0;

    function automatic logic is_zero_reg(input logic [WB_S_INDEX-1:0] d);
        return d == WB_ZERO_REG;
    endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Result-collection and register-file write-port bundle of the writeback arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int num_sources     = WB_NUM_SOURCES,
    parameter int num_write_ports = WB_NUM_WRITE_PORTS,
    parameter int s_index         = WB_S_INDEX,
    parameter int s_width         = WB_S_WIDTH
) ();
    logic [num_sources-1:0]                  src_valid;
    logic [num_sources-1:0]                  src_ready;
    logic [num_sources-1:0][s_index-1:0]     src_dest;
    logic [num_sources-1:0][s_width-1:0]     src_data;
    logic [num_write_ports-1:0]              ld;
    logic [num_write_ports-1:0][s_index-1:0] dest;
    logic [num_write_ports-1:0][s_width-1:0] in;
    logic                                    busy;

    modport master (
        input  src_valid, src_dest, src_data,
        output src_ready, ld, dest, in, busy
    );

    modport slave (
        output src_valid, src_dest, src_data,
        input  src_ready, ld, dest, in, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO; the head entry is visible combinationally for arbitration.
// Pushes while full and pops while empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int fifo_depth = WB_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);
    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [fifo_depth];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(fifo_depth));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers functional-unit results and grants up to num_write_ports
// of them per cycle, round-robin, onto registered register-file write ports.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int num_sources     = WB_NUM_SOURCES,
    parameter int num_write_ports = WB_NUM_WRITE_PORTS,
    parameter int s_index         = WB_S_INDEX,
    parameter int s_width         = WB_S_WIDTH,
    parameter int fifo_depth      = WB_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.master  bus
);
    localparam int NS    = num_sources;
    localparam int NWP   = num_write_ports;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

    logic [NS-1:0]              w_full;
    logic [NS-1:0]              w_empty;
    logic [NS-1:0]              w_push;
    logic [NS-1:0]              w_pop;
    wb_entry_t                  w_head  [NS];
    wb_entry_t                  w_wdata [NS];

    logic [IDX_W-1:0]           r_rr_ptr;
    logic [IDX_W-1:0]           w_rr_next;
    logic [NWP-1:0]             w_ld;
    logic [NWP-1:0][s_index-1:0] w_dest;
    logic [NWP-1:0][s_width-1:0] w_data;
    logic [NWP-1:0]             r_ld;
    logic [NWP-1:0][s_index-1:0] r_dest;
    logic [NWP-1:0][s_width-1:0] r_data;

    assign bus.src_ready = {NS{rst}} & ~w_full;
    assign w_push        = bus.src_valid & bus.src_ready;

    for (genvar g = 0; g < NS; g++) begin : g_src
        assign w_wdata[g] = {bus.src_dest[g], bus.src_data[g]};

        wb_fifo #(.fifo_depth(fifo_depth)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_wdata (w_wdata[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );
    end

    // Round-robin scan; zero-register heads are dropped without using a port,
    // and a head whose dest was already granted this cycle waits in its FIFO.
    always_comb begin
        int        n_grant;
        int        last;
        int        idx;
        int        nxt;
        logic      any;
        logic      v_empty;
        logic      v_conflict;
        wb_entry_t v_head;

        w_pop      = '0;
        w_ld       = '0;
        w_dest     = '0;
        w_data     = '0;
        n_grant    = 0;
        last       = 0;
        idx        = 0;
        nxt        = 0;
        any        = 1'b0;
        v_empty    = 1'b1;
        v_conflict = 1'b0;
        v_head     = '0;

        for (int k = 0; k < NS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NS) idx = idx - NS;
            v_empty = 1'b1;
            v_head  = '0;
            for (int s = 0; s < NS; s++) begin
                if (s == idx) begin
                    v_empty = w_empty[s];
                    v_head  = w_head[s];
                end
            end
            if (!v_empty && n_grant < NWP) begin
                v_conflict = 1'b0;
                for (int j = 0; j < NWP; j++) begin
                    if (j < n_grant && w_dest[j] == v_head.dest) v_conflict = 1'b1;
                end
                if (is_zero_reg(v_head.dest) || !v_conflict) begin
                    for (int s = 0; s < NS; s++) begin
                        if (s == idx) w_pop[s] = 1'b1;
                    end
                    any  = 1'b1;
                    last = idx;
                end
                if (!is_zero_reg(v_head.dest) && !v_conflict) begin
                    for (int j = 0; j < NWP; j++) begin
                        if (j == n_grant) begin
                            w_ld[j]   = 1'b1;
                            w_dest[j] = v_head.dest;
                            w_data[j] = v_head.data;
                        end
                    end
                    n_grant = n_grant + 1;
                end
            end
        end

        nxt = last + 1;
        if (nxt >= NS) nxt = 0;
        w_rr_next = any ? IDX_W'(nxt) : r_rr_ptr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_ld     <= '0;
            r_dest   <= '0;
            r_data   <= '0;
        end else begin
            r_rr_ptr <= w_rr_next;
            r_ld     <= w_ld;
            for (int j = 0; j < NWP; j++) begin
                if (w_ld[j]) begin
                    r_dest[j] <= w_dest[j];
                    r_data[j] <= w_data[j];
                end
            end
        end
    end

    assign bus.ld   = r_ld;
    assign bus.dest = r_dest;
    assign bus.in   = r_data;
    assign bus.busy = (|(~w_empty)) | (|r_ld);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write, oversubscription with
// round-robin fairness, zero-register drop, same-dest conflict and mid-stream reset.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] rf [32];
    int   gcnt [4];

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, and the write
    // ports are applied to a small register-file image.
    task automatic step();
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            if (bus.ld[j]) rf[bus.dest[j]] = bus.in[j];
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.src_valid = 4'h0;
        step();
        rst = 1'b1;
    endtask

    task automatic count_grants();
        for (int j = 0; j < 3; j++) begin
            for (int s = 0; s < 4; s++) begin
                if (bus.ld[j] && bus.dest[j] == 5'(s + 1)) gcnt[s]++;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int r = 0; r < 32; r++) rf[r] = 32'h0;
        for (int s = 0; s < 4; s++) gcnt[s] = 0;

        // Reset held for two cycles with every source offering data
        rst = 1'b0;
        bus.src_valid = 4'hF;
        bus.src_dest  = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.src_data  = {32'h33, 32'h22, 32'h11, 32'h10};
        step();
        chk("rst_ld_c0", 32'(bus.ld), 0);
        chk("rst_ready_c0", 32'(bus.src_ready), 0);
        step();
        chk("rst_ld_c1", 32'(bus.ld), 0);
        chk("rst_ready_c1", 32'(bus.src_ready), 0);
        rst = 1'b1;
        bus.src_valid = 4'h0;
        #1;
        chk("rel_ready", 32'(bus.src_ready), 'hF);
        chk("rel_busy", 32'(bus.busy), 0);
        step();
        chk("rel_ld_c0", 32'(bus.ld), 0);
        chk("rel_busy_c0", 32'(bus.busy), 0);
        chk("rel_ready_c0", 32'(bus.src_ready), 'hF);
        step();
        chk("rel_ld_c1", 32'(bus.ld), 0);
        chk("rel_no_write", rf[1], 0);

        // Single write from source 2
        do_reset();
        bus.src_valid = 4'b0100;
        bus.src_dest  = {5'd0, 5'd7, 5'd0, 5'd0};
        bus.src_data  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        step();
        bus.src_valid = 4'h0;
        chk("single_ld_t1", 32'(bus.ld), 0);
        chk("single_busy_t1", 32'(bus.busy), 1);
        step();
        chk("single_ld_t2", 32'(bus.ld), 'b001);
        chk("single_dest_t2", 32'(bus.dest[0]), 7);
        chk("single_in_t2", bus.in[0], 'hDEADBEEF);
        chk("single_busy_t2", 32'(bus.busy), 1);
        step();
        chk("single_ld_t3", 32'(bus.ld), 0);
        chk("single_busy_t3", 32'(bus.busy), 0);

        // Oversubscription: four results, three ports
        do_reset();
        bus.src_valid = 4'hF;
        bus.src_dest  = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.src_data  = {32'h103, 32'h102, 32'h101, 32'h100};
        step();
        bus.src_valid = 4'h0;
        step();
        chk("over_ld_w1", 32'(bus.ld), 'b111);
        chk("over_dest0_w1", 32'(bus.dest[0]), 1);
        chk("over_dest1_w1", 32'(bus.dest[1]), 2);
        chk("over_dest2_w1", 32'(bus.dest[2]), 3);
        chk("over_in2_w1", bus.in[2], 'h102);
        step();
        chk("over_ld_w2", 32'(bus.ld), 'b001);
        chk("over_dest0_w2", 32'(bus.dest[0]), 4);
        chk("over_in0_w2", bus.in[0], 'h103);
        step();
        chk("over_ld_w3", 32'(bus.ld), 0);

        // Continuous offers from every source, starting from rr_ptr==0
        bus.src_valid = 4'hF;
        step();
        chk("cont_ld_e1", 32'(bus.ld), 0);
        step();
        count_grants();
        chk("cont_ld_e2", 32'(bus.ld), 'b111);
        chk("cont_dest0_e2", 32'(bus.dest[0]), 1);
        chk("cont_ready_e2", 32'(bus.src_ready), 'b0111);
        step();
        count_grants();
        chk("cont_ld_e3", 32'(bus.ld), 'b111);
        chk("cont_dest0_e3", 32'(bus.dest[0]), 4);
        chk("cont_ready_e3", 32'(bus.src_ready), 'b1011);
        step();
        count_grants();
        chk("cont_ld_e4", 32'(bus.ld), 'b111);
        chk("cont_dest0_e4", 32'(bus.dest[0]), 3);
        chk("cont_ready_e4", 32'(bus.src_ready), 'b1101);
        step();
        count_grants();
        chk("cont_ld_e5", 32'(bus.ld), 'b111);
        chk("cont_dest0_e5", 32'(bus.dest[0]), 2);
        chk("cont_ready_e5", 32'(bus.src_ready), 'b1110);
        chk("fair_s0", gcnt[0], 3);
        chk("fair_s1", gcnt[1], 3);
        chk("fair_s2", gcnt[2], 3);
        chk("fair_s3", gcnt[3], 3);
        bus.src_valid = 4'h0;

        // Zero-register head mixed with real writes
        do_reset();
        bus.src_valid = 4'b0111;
        bus.src_dest  = {5'd0, 5'd8, 5'd0, 5'd6};
        bus.src_data  = {32'h0, 32'h80, 32'h5, 32'h60};
        step();
        bus.src_valid = 4'h0;
        step();
        chk("zero_ld", 32'(bus.ld), 'b011);
        chk("zero_dest0", 32'(bus.dest[0]), 6);
        chk("zero_in0", bus.in[0], 'h60);
        chk("zero_dest1", 32'(bus.dest[1]), 8);
        chk("zero_in1", bus.in[1], 'h80);
        step();
        chk("zero_ld_after", 32'(bus.ld), 0);
        chk("zero_busy_after", 32'(bus.busy), 0);

        // Zero-register head alone
        do_reset();
        bus.src_valid = 4'b0010;
        bus.src_dest  = {5'd0, 5'd0, 5'd0, 5'd0};
        bus.src_data  = {32'h0, 32'h0, 32'h5, 32'h0};
        step();
        bus.src_valid = 4'h0;
        chk("zonly_busy_t1", 32'(bus.busy), 1);
        step();
        chk("zonly_ld_t2", 32'(bus.ld), 0);
        chk("zonly_busy_t2", 32'(bus.busy), 0);
        chk("zonly_rf0", rf[0], 0);

        // Same-destination conflict between sources 0 and 1
        do_reset();
        bus.src_valid = 4'b0011;
        bus.src_dest  = {5'd0, 5'd0, 5'd9, 5'd9};
        bus.src_data  = {32'h0, 32'h0, 32'hBBBB, 32'hAAAA};
        step();
        bus.src_valid = 4'h0;
        step();
        chk("conf_ld_w1", 32'(bus.ld), 'b001);
        chk("conf_dest_w1", 32'(bus.dest[0]), 9);
        chk("conf_in_w1", bus.in[0], 'hAAAA);
        chk("conf_busy_w1", 32'(bus.busy), 1);
        step();
        chk("conf_ld_w2", 32'(bus.ld), 'b001);
        chk("conf_in_w2", bus.in[0], 'hBBBB);
        step();
        chk("conf_ld_w3", 32'(bus.ld), 0);
        chk("conf_rf9", rf[9], 'hBBBB);

        // Backpressure on source 3, then reset with entries still queued
        do_reset();
        bus.src_valid = 4'hF;
        bus.src_dest  = {5'd14, 5'd13, 5'd12, 5'd11};
        bus.src_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        step();
        step();
        chk("bp_ready", 32'(bus.src_ready), 'b0111);
        rst = 1'b0;
        #1;
        chk("bp_ready_in_rst", 32'(bus.src_ready), 0);
        step();
        chk("bp_ld_rst", 32'(bus.ld), 0);
        chk("bp_busy_rst", 32'(bus.busy), 0);
        rst = 1'b1;
        bus.src_valid = 4'h0;
        #1;
        chk("bp_ready_rel", 32'(bus.src_ready), 'hF);
        step();
        chk("bp_ld_p1", 32'(bus.ld), 0);
        step();
        chk("bp_ld_p2", 32'(bus.ld), 0);
        chk("bp_busy_p2", 32'(bus.busy), 0);
        chk("bp_rf14", rf[14], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
